// File: rtl/fifo_drain_if.sv
// Stream bundle for fifo_drain: pop side toward the fifo and the valid/ready
// output stream toward the consumer.
interface fifo_drain_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  pop;
    logic                  q_empty;
    logic [DATA_WIDTH-1:0] q_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output pop,
        input  q_empty,
        input  q_data,
        output out_valid,
        input  out_ready,
        output out_data
    );

    modport slave (
        input  pop,
        output q_empty,
        output q_data,
        input  out_valid,
        output out_ready,
        input  out_data
    );
endinterface

// File: rtl/fifo_drain.sv
// Pop-side consumer for a registered-output fifo: issues pops, captures q_data
// one cycle later, and re-presents entries through a 2-slot valid/ready buffer.

module fifo_drain_chk #(
    parameter int DATA_WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  capture,
    input logic                  fire,
    input logic                  full,
    input logic                  pop,
    input logic                  q_empty,
    input logic                  out_valid,
    input logic                  out_ready,
    input logic [DATA_WIDTH-1:0] out_data
);
    // A capture into a full buffer with nothing leaving would drop an entry.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && full && !fire));

    a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && q_empty));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));
endmodule

module fifo_drain #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    fifo_drain_if.master         bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] delivered
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  pend_q, pend_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
    logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
    logic [CNT_WIDTH-1:0]  delivered_q, delivered_d;

    logic                  fire_s;
    logic                  capture_s;
    logic                  pop_s;
    logic [1:0]            occ_s;
    logic [2:0]            load_s;

    // Occupancy, handshake and pop decision; load_s is what the buffer would
    // hold once this cycle's fire and the in-flight capture both settle.
    always_comb begin
        case (state_q)
            EMPTY:   occ_s = 2'd0;
            ONE:     occ_s = 2'd1;
            TWO:     occ_s = 2'd2;
            default: occ_s = 2'd0;
        endcase
        fire_s    = valid_q & bus.out_ready;
        capture_s = pend_q;
        load_s    = {1'b0, occ_s} + {2'b00, pend_q} - {2'b00, fire_s};
        pop_s     = rst_n & en & ~bus.q_empty & (load_s <= 3'd1);
    end

    // Buffer FSM: slot0 is the head; capture lands at the tail after any fire.
    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        pend_d  = pop_s;
        case (state_q)
            EMPTY: begin
                if (capture_s) begin
                    slot0_d = bus.q_data;
                    state_d = ONE;
                end else begin
                    state_d = EMPTY;
                end
            end
            ONE: begin
                if (capture_s && fire_s) begin
                    slot0_d = bus.q_data;
                    state_d = ONE;
                end else if (capture_s) begin
                    slot1_d = bus.q_data;
                    state_d = TWO;
                end else if (fire_s) begin
                    state_d = EMPTY;
                end else begin
                    state_d = ONE;
                end
            end
            TWO: begin
                if (capture_s && fire_s) begin
                    slot0_d = slot1_q;
                    slot1_d = bus.q_data;
                    state_d = TWO;
                end else if (fire_s) begin
                    slot0_d = slot1_q;
                    state_d = ONE;
                end else begin
                    state_d = TWO;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        valid_d = (state_d != EMPTY);
    end

    // Delivered-entry counter, wrapping naturally at 2^CNT_WIDTH.
    always_comb begin
        if (fire_s) begin
            delivered_d = delivered_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            delivered_d = delivered_q;
        end
    end

    // State registers; an in-flight pop is discarded by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            pend_q      <= 1'b0;
            valid_q     <= 1'b0;
            slot0_q     <= {DATA_WIDTH{1'b0}};
            slot1_q     <= {DATA_WIDTH{1'b0}};
            delivered_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            valid_q     <= valid_d;
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
            delivered_q <= delivered_d;
        end
    end

    assign bus.pop       = pop_s;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = slot0_q;
    assign busy          = valid_q | pend_q;
    assign delivered     = delivered_q;

    fifo_drain_chk #(.DATA_WIDTH(DATA_WIDTH)) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (capture_s),
        .fire      (fire_s),
        .full      (state_q == TWO),
        .pop       (pop_s),
        .q_empty   (bus.q_empty),
        .out_valid (valid_q),
        .out_ready (bus.out_ready),
        .out_data  (slot0_q)
    );
endmodule
